// File: rtl/event_encoder.sv
// One-hot event encoder: captures request pulses as sticky pending bits and
// hands their indices out one at a time, round-robin, over a valid/ready port.
module event_encoder #(
    parameter int BIN_W = 9,
    parameter int VEC_W = (1 << BIN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [VEC_W-1:0] req_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BIN_W-1:0] binary_out,
    output logic [BIN_W:0]   pending_count,
    output logic             overflow
);

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [VEC_W-1:0] pending;
    logic [VEC_W-1:0] pending_next;
    logic [VEC_W-1:0] load_mask;
    logic [VEC_W-1:0] above_mask;
    logic [VEC_W-1:0] above_req;
    logic [BIN_W-1:0] pointer;
    logic [BIN_W-1:0] pointer_next;
    logic [BIN_W-1:0] binary_next;
    logic [BIN_W-1:0] grant_idx;
    logic             overflow_next;
    logic             accept;
    logic             load;

    // Scanning from the top down lets the lowest set bit win.
    function automatic logic [BIN_W-1:0] lowest_set(input logic [VEC_W-1:0] v);
        logic [BIN_W-1:0] idx;
        idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (v[i]) idx = BIN_W'(i);
        end
        return idx;
    endfunction

    // Bits strictly above the pointer are searched first; failing that the
    // search wraps round to the lowest pending bit.
    always_comb begin
        above_mask = '0;
        for (int i = 0; i < VEC_W; i++) begin
            above_mask[i] = (i > int'(pointer));
        end
    end

    always_comb begin
        above_req     = pending & above_mask;
        grant_idx     = (|above_req) ? lowest_set(above_req) : lowest_set(pending);
        accept        = (state == HOLD) && out_ready;
        load          = (state == EMPTY) || accept;
        load_mask     = '0;
        state_next    = state;
        pointer_next  = pointer;
        binary_next   = binary_out;
        if (load) begin
            if (|pending) begin
                load_mask[grant_idx] = 1'b1;
                binary_next          = grant_idx;
                pointer_next         = grant_idx;
                state_next           = HOLD;
            end else begin
                state_next = EMPTY;
            end
        end
        // A fresh request overrides the clear of the bit being loaded.
        pending_next  = (pending & ~load_mask) | (enable ? req_in : '0);
        overflow_next = enable & (|(req_in & pending & ~load_mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            pending    <= '0;
            pointer    <= BIN_W'(VEC_W - 1);
            binary_out <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            pointer    <= pointer_next;
            binary_out <= binary_next;
            overflow   <= overflow_next;
        end
    end

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < VEC_W; i++) begin
            pending_count = pending_count + (BIN_W + 1)'(pending[i]);
        end
    end

    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_event_encoder.sv
// Bench for event_encoder at BIN_W=3: directed pulses queue their expected
// grant indices, and a negedge monitor pops and compares on every accept.
module tb_event_encoder;

    localparam int BIN_W = 3;
    localparam int VEC_W = 8;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [VEC_W-1:0] req_in;
    logic             out_ready;
    logic             out_valid;
    logic [BIN_W-1:0] binary_out;
    logic [BIN_W:0]   pending_count;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int sb_q[$];

    event_encoder #(
        .BIN_W(BIN_W),
        .VEC_W(VEC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req_in       (req_in),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .binary_out   (binary_out),
        .pending_count(pending_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [VEC_W-1:0] req, input logic rdy, input logic en);
        req_in    = req;
        out_ready = rdy;
        enable    = en;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted grant must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_grant: got %0d, expected none at %0t", binary_out, $time);
            end else begin
                check_output("grant_index", int'(binary_out), sb_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        apply_stimulus(8'h00, 1'b0, 1'b1);
        repeat (2) step();
        check_output("reset_valid", int'(out_valid), 0);
        check_output("reset_binary", int'(binary_out), 0);
        check_output("reset_count", int'(pending_count), 0);
        check_output("reset_overflow", int'(overflow), 0);
        rst = 1'b0;

        // Single pulse on bit 2: visible two edges later for one cycle.
        apply_stimulus(8'h04, 1'b1, 1'b1);
        sb_q.push_back(2);
        step();
        apply_stimulus(8'h00, 1'b1, 1'b1);
        check_output("latency_not_yet", int'(out_valid), 0);
        step();
        check_output("grant2_valid", int'(out_valid), 1);
        check_output("grant2_binary", int'(binary_out), 2);
        step();
        check_output("grant2_one_cycle", int'(out_valid), 0);

        // Bits 7 and 1 with pointer at 2: 7 first, then wrap to 1.
        apply_stimulus(8'h82, 1'b1, 1'b1);
        sb_q.push_back(7);
        sb_q.push_back(1);
        step();
        apply_stimulus(8'h00, 1'b1, 1'b1);
        step();
        check_output("rr_first", int'(binary_out), 7);
        step();
        check_output("rr_second_valid", int'(out_valid), 1);
        check_output("rr_second", int'(binary_out), 1);
        step();
        check_output("rr_drained", int'(out_valid), 0);

        // Asynchronous reset while holding index 4 with bit 5 still pending.
        apply_stimulus(8'h30, 1'b0, 1'b1);
        step();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        step();
        check_output("pre_reset_binary", int'(binary_out), 4);
        check_output("pre_reset_count", int'(pending_count), 1);
        #2 rst = 1'b1;
        #1;
        check_output("async_reset_valid", int'(out_valid), 0);
        check_output("async_reset_binary", int'(binary_out), 0);
        check_output("async_reset_count", int'(pending_count), 0);
        check_output("async_reset_overflow", int'(overflow), 0);
        sb_q.delete();
        step();
        rst = 1'b0;

        // Pointer back at 7: index 0 held under backpressure, then 5.
        apply_stimulus(8'h21, 1'b0, 1'b1);
        sb_q.push_back(0);
        sb_q.push_back(5);
        step();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            check_output("stall_valid", int'(out_valid), 1);
            check_output("stall_binary", int'(binary_out), 0);
            step();
        end
        apply_stimulus(8'h00, 1'b1, 1'b1);
        step();
        check_output("after_stall", int'(binary_out), 5);
        step();
        check_output("after_stall_drained", int'(out_valid), 0);

        // Duplicate on pending bit 3 overflows; a request for the in-flight index does not.
        apply_stimulus(8'h01, 1'b0, 1'b1);
        sb_q.push_back(0);
        sb_q.push_back(3);
        sb_q.push_back(0);
        step();
        apply_stimulus(8'h08, 1'b0, 1'b1);
        step();
        check_output("ovf_setup_binary", int'(binary_out), 0);
        check_output("ovf_setup_count", int'(pending_count), 1);
        check_output("ovf_setup_flag", int'(overflow), 0);
        step();
        check_output("ovf_flag", int'(overflow), 1);
        check_output("ovf_count", int'(pending_count), 1);
        apply_stimulus(8'h01, 1'b0, 1'b1);
        step();
        check_output("inflight_no_ovf", int'(overflow), 0);
        check_output("inflight_count", int'(pending_count), 2);
        apply_stimulus(8'h00, 1'b1, 1'b1);
        step();
        check_output("ovf_drain_a", int'(binary_out), 3);
        step();
        check_output("ovf_drain_b", int'(binary_out), 0);
        step();
        check_output("ovf_drained", int'(out_valid), 0);

        // Disabled capture ignores a full request vector.
        apply_stimulus(8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            check_output("disabled_count", int'(pending_count), 0);
            check_output("disabled_valid", int'(out_valid), 0);
            check_output("disabled_overflow", int'(overflow), 0);
        end
        apply_stimulus(8'h00, 1'b1, 1'b1);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
        check_output("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
